uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8-bit asynchronous serial receiver with optional parity and
//             mid-bit sampling; one-cycle valid pulse per completed frame.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter logic [1:0]  EN_PARITY  = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_uart_data,
    output logic       o_uart_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_uart_busy
);

    localparam logic [12:0] c_mcnt    = 13'(CLOCK_FREQ / BAUD_RATE - 1);
    localparam logic [12:0] c_half    = c_mcnt / 13'd2;
    localparam logic        c_par_en  = (EN_PARITY == 2'b11) || (EN_PARITY == 2'b01);
    localparam logic        c_par_odd = (EN_PARITY == 2'b11);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RX     = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [12:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_par_err;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_d;
    logic        w_par_exp;

    assign w_par_exp = c_par_odd ? ~^r_shift : ^r_shift;

    // Synchronizer and history flop idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 13'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_par_err    <= 1'b0;
            o_uart_data  <= 8'd0;
            o_uart_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_uart_busy  <= 1'b0;
        end else begin
            o_uart_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_rx_d && !r_rx_s) begin
                        r_state     <= ST_START;
                        o_uart_busy <= 1'b1;
                        r_cnt       <= 13'd0;
                        r_bit_idx   <= 3'd0;
                    end else begin
                        o_uart_busy <= 1'b0;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_half) begin
                        r_cnt   <= 13'd0;
                        r_state <= r_rx_s ? ST_IDLE : ST_RX;
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
                ST_RX: begin
                    if (r_cnt == c_mcnt) begin
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_cnt              <= 13'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
                ST_PARITY: begin
                    if (r_cnt == c_mcnt) begin
                        r_par_err <= (r_rx_s != w_par_exp);
                        r_cnt     <= 13'd0;
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                    if (r_cnt == c_mcnt) begin
                        o_uart_data  <= r_shift;
                        o_uart_valid <= 1'b1;
                        o_frame_err  <= ~r_rx_s;
                        o_parity_err <= c_par_en ? r_par_err : 1'b0;
                        r_cnt        <= 13'd0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 13'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 13'd0;
                    r_bit_idx   <= 3'd0;
                    o_uart_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx in no/even/odd parity builds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_bit = 16;

    logic       clk;
    logic       rst_n;
    logic [2:0] rx;
    logic [7:0] data [3];
    logic [2:0] valid;
    logic [2:0] perr;
    logic [2:0] ferr;
    logic [2:0] busy;
    logic [2:0] prev_valid;

    int n_cmp;
    int n_err;

    // Expected frames per instance packed as {frame_err, parity_err, data}.
    logic [9:0] exp_q [3][$];

    uart_rx #(.CLOCK_FREQ(16), .BAUD_RATE(1), .EN_PARITY(2'b00)) u_dut_none (
        .clk(clk), .rst_n(rst_n), .i_uart_rx(rx[0]), .o_uart_data(data[0]),
        .o_uart_valid(valid[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
        .o_uart_busy(busy[0])
    );
    uart_rx #(.CLOCK_FREQ(16), .BAUD_RATE(1), .EN_PARITY(2'b01)) u_dut_even (
        .clk(clk), .rst_n(rst_n), .i_uart_rx(rx[1]), .o_uart_data(data[1]),
        .o_uart_valid(valid[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
        .o_uart_busy(busy[1])
    );
    uart_rx #(.CLOCK_FREQ(16), .BAUD_RATE(1), .EN_PARITY(2'b11)) u_dut_odd (
        .clk(clk), .rst_n(rst_n), .i_uart_rx(rx[2]), .o_uart_data(data[2]),
        .o_uart_valid(valid[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
        .o_uart_busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instance 1 wants an even total count of ones over data+parity, instance 2 an odd one.
    function automatic logic model_perr(input int k, input logic [7:0] d, input logic p);
        int ones;
        ones = $countones({d, p});
        if (k == 1) return (ones % 2) != 0;
        if (k == 2) return (ones % 2) == 0;
        return 1'b0;
    endfunction

    task automatic check_frame(input int k);
        logic [9:0] e;
        check_val($sformatf("u%0d_valid_one_cycle", k), 32'(prev_valid[k]), 32'd0);
        if (exp_q[k].size() == 0) begin
            check_val($sformatf("u%0d_unexpected_valid", k), 32'(valid[k]), 32'd0);
        end else begin
            e = exp_q[k].pop_front();
            check_val($sformatf("u%0d_data", k), 32'(data[k]), 32'(e[7:0]));
            check_val($sformatf("u%0d_parity_err", k), 32'(perr[k]), 32'(e[8]));
            check_val($sformatf("u%0d_frame_err", k), 32'(ferr[k]), 32'(e[9]));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (valid[k]) check_frame(k);
            end
        end
        prev_valid <= valid;
    end

    task automatic send_bit(input int k, input logic b);
        rx[k] = b;
        repeat (c_bit) @(negedge clk);
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input logic p, input logic stop);
        exp_q[k].push_back({~stop, model_perr(k, d, p), d});
        send_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(k, d[i]);
        if (k != 0) send_bit(k, p);
        send_bit(k, stop);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("%s_u%0d_data", tag, k), 32'(data[k]), 32'd0);
            check_val($sformatf("%s_u%0d_valid", tag, k), 32'(valid[k]), 32'd0);
            check_val($sformatf("%s_u%0d_perr", tag, k), 32'(perr[k]), 32'd0);
            check_val($sformatf("%s_u%0d_ferr", tag, k), 32'(ferr[k]), 32'd0);
            check_val($sformatf("%s_u%0d_busy", tag, k), 32'(busy[k]), 32'd0);
        end
    endtask

    initial begin
        int         k;
        logic [7:0] d;
        logic       p;
        logic       stop;
        int         gap;

        n_cmp      = 0;
        n_err      = 0;
        rx         = 3'b111;
        rst_n      = 1'b0;
        prev_valid = 3'b000;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2 * c_bit) @(negedge clk);

        // Plain frame, no parity.
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        check_val("a5_busy_after", 32'(busy[0]), 32'd0);
        check_val("a5_data_held", 32'(data[0]), 32'hA5);

        // Short low glitch is rejected at mid-start-bit.
        rx[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_val("glitch_busy_rise", 32'(busy[0]), 32'd1);
        repeat (14) @(negedge clk);
        check_val("glitch_busy_fall", 32'(busy[0]), 32'd0);
        check_val("glitch_data_kept", 32'(data[0]), 32'hA5);
        repeat (c_bit) @(negedge clk);

        // Stop bit low followed by a held-low break, then recovery.
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        repeat (4) send_bit(0, 1'b0);
        check_val("break_busy", 32'(busy[0]), 32'd0);
        repeat (2) send_bit(0, 1'b1);
        send_frame(0, 8'h81, 1'b0, 1'b1);

        // Even and odd parity directed cases.
        send_frame(1, 8'h07, 1'b1, 1'b1);
        send_frame(1, 8'h07, 1'b0, 1'b1);
        send_frame(2, 8'h00, 1'b1, 1'b1);
        send_bit(2, 1'b1);

        // Randomized frames across all three builds.
        for (int it = 0; it < 24; it++) begin
            k    = it % 3;
            d    = 8'($urandom_range(0, 255));
            p    = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(0, 2);
            if (!stop && gap == 0) gap = 1;
            send_frame(k, d, p, stop);
            repeat (gap) send_bit(k, 1'b1);
        end
        repeat (2 * c_bit) @(negedge clk);

        // Back-to-back frames, then reset in the middle of a third.
        send_frame(0, 8'h55, 1'b0, 1'b1);
        send_frame(0, 8'hAA, 1'b0, 1'b1);
        check_val("b2b_data", 32'(data[0]), 32'hAA);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midreset");
        rst_n = 1'b1;
        repeat (3 * c_bit) @(negedge clk);
        check_val("post_reset_data", 32'(data[0]), 32'd0);
        check_val("post_reset_busy", 32'(busy[0]), 32'd0);

        for (int j = 0; j < 3; j++) begin
            check_val($sformatf("u%0d_pending_frames", j), 32'(exp_q[j].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
